// File: rtl/imem_arbiter.sv
// Two-port (fetch/debug) arbiter and single-slot response sequencer for the instruction memory.
// Optional grant counters are enabled by defining IMEM_ARB_GRANT_CNT_EN.
module imem_arbiter #(
    parameter int unsigned AW    = 6,
    parameter int unsigned DW    = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             f_req_valid,
    output logic             f_req_ready,
    input  logic [AW-1:0]    f_req_addr,
    output logic             f_resp_valid,
    input  logic             f_resp_ready,
    output logic [DW-1:0]    f_resp_data,
    input  logic             d_req_valid,
    output logic             d_req_ready,
    input  logic [AW-1:0]    d_req_addr,
    output logic             d_resp_valid,
    input  logic             d_resp_ready,
    output logic [DW-1:0]    d_resp_data,
    input  logic             flush,
    output logic [AW-1:0]    mem_addr,
    input  logic [DW-1:0]    mem_rdata,
    output logic [CNT_W-1:0] f_grant_cnt,
    output logic [CNT_W-1:0] d_grant_cnt
);

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StHold = 1'b1;
    localparam logic PortF = 1'b0;
    localparam logic PortD = 1'b1;

    logic [0:0]    state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_grant_q, last_grant_d;
    logic [DW-1:0] resp_data_q, resp_data_d;

    logic free;
    logic f_elig, d_elig;
    logic grant_f, grant_d;

    always_comb begin
        f_resp_valid = (state_q == StHold) && (owner_q == PortF);
        d_resp_valid = (state_q == StHold) && (owner_q == PortD);
        f_resp_data  = resp_data_q;
        d_resp_data  = resp_data_q;

        free = (state_q == StIdle)
            || (f_resp_valid && f_resp_ready)
            || (d_resp_valid && d_resp_ready)
            || (f_resp_valid && flush);

        // A redirect blocks new fetches in the same cycle; debug may still proceed.
        f_elig = f_req_valid && !flush;
        d_elig = d_req_valid;

        grant_f = free && f_elig && (!d_elig || last_grant_q == PortD);
        grant_d = free && d_elig && (!f_elig || last_grant_q == PortF);

        f_req_ready = grant_f;
        d_req_ready = grant_d;

        if (grant_f) begin
            mem_addr = f_req_addr;
        end else if (grant_d) begin
            mem_addr = d_req_addr;
        end else begin
            mem_addr = '0;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        resp_data_d  = resp_data_q;
        if (grant_f || grant_d) begin
            state_d      = StHold;
            owner_d      = grant_d ? PortD : PortF;
            last_grant_d = grant_d ? PortD : PortF;
            resp_data_d  = mem_rdata;
        end else if (free) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            owner_q      <= PortF;
            last_grant_q <= PortD;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            resp_data_q  <= resp_data_d;
        end
    end

`ifdef IMEM_ARB_GRANT_CNT_EN
    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] f_cnt_q, f_cnt_d;
    logic [CNT_W-1:0] d_cnt_q, d_cnt_d;

    // Counters saturate at all-ones rather than wrapping.
    always_comb begin
        f_cnt_d = f_cnt_q;
        d_cnt_d = d_cnt_q;
        if (grant_f && (f_cnt_q != '1)) begin
            f_cnt_d = f_cnt_q + CntOne;
        end
        if (grant_d && (d_cnt_q != '1)) begin
            d_cnt_d = d_cnt_q + CntOne;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_cnt_q <= '0;
            d_cnt_q <= '0;
        end else begin
            f_cnt_q <= f_cnt_d;
            d_cnt_q <= d_cnt_d;
        end
    end

    assign f_grant_cnt = f_cnt_q;
    assign d_grant_cnt = d_cnt_q;
`else
    assign f_grant_cnt = '0;
    assign d_grant_cnt = '0;
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard bench for imem_arbiter: stimulus pushes expected response data per port,
// a negedge monitor compares and pops on handshake (or on flush for the fetch slot).
module tb_imem_arbiter;

    localparam int unsigned AW    = 6;
    localparam int unsigned DW    = 32;
    localparam int unsigned CNT_W = 2;
`ifdef IMEM_ARB_GRANT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             f_req_valid = 1'b0, f_req_ready;
    logic [AW-1:0]    f_req_addr = '0;
    logic             f_resp_valid, f_resp_ready = 1'b0;
    logic [DW-1:0]    f_resp_data;
    logic             d_req_valid = 1'b0, d_req_ready;
    logic [AW-1:0]    d_req_addr = '0;
    logic             d_resp_valid, d_resp_ready = 1'b0;
    logic [DW-1:0]    d_resp_data;
    logic             flush = 1'b0;
    logic [AW-1:0]    mem_addr;
    logic [DW-1:0]    mem_rdata;
    logic [CNT_W-1:0] f_grant_cnt, d_grant_cnt;

    logic [DW-1:0] mem [64];
    logic [DW-1:0] f_q[$];
    logic [DW-1:0] d_q[$];
    int n_pass = 0;
    int n_total = 0;

    assign mem_rdata = mem[mem_addr];

    always #5 clk = ~clk;

    imem_arbiter #(.AW(AW), .DW(DW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .f_req_valid(f_req_valid), .f_req_ready(f_req_ready), .f_req_addr(f_req_addr),
        .f_resp_valid(f_resp_valid), .f_resp_ready(f_resp_ready), .f_resp_data(f_resp_data),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
        .d_resp_valid(d_resp_valid), .d_resp_ready(d_resp_ready), .d_resp_data(d_resp_data),
        .flush(flush), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .f_grant_cnt(f_grant_cnt), .d_grant_cnt(d_grant_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic note_fail(input string name);
        n_total++;
        $display("FAIL %s: response present, none expected", name);
    endtask

    function automatic logic [31:0] sat(input int n);
        return CNT_EN ? 32'((n > 3) ? 3 : n) : 32'd0;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        f_req_valid = 1'b0; d_req_valid = 1'b0; flush = 1'b0;
        f_resp_ready = 1'b0; d_resp_ready = 1'b0;
        f_req_addr = '0; d_req_addr = '0;
        f_q.delete(); d_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (f_resp_valid) begin
                if (f_q.size() == 0) note_fail("f_resp_spurious");
                else begin
                    check("f_resp_data", f_resp_data, f_q[0]);
                    if (f_resp_ready || flush) void'(f_q.pop_front());
                end
            end
            if (d_resp_valid) begin
                if (d_q.size() == 0) note_fail("d_resp_spurious");
                else begin
                    check("d_resp_data", d_resp_data, d_q[0]);
                    if (d_resp_ready) void'(d_q.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | (i << 8) | i;
        mem[5] = 32'h0050_0093;

        // Reset values
        rst_n = 1'b0;
        #3;
        check("rst_f_req_ready", f_req_ready, 0);
        check("rst_d_req_ready", d_req_ready, 0);
        check("rst_f_resp_valid", f_resp_valid, 0);
        check("rst_d_resp_valid", d_resp_valid, 0);
        check("rst_resp_data", f_resp_data, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_f_cnt", f_grant_cnt, 0);
        do_reset();

        // Single fetch, one-cycle latency
        f_req_valid = 1'b1; f_req_addr = 6'd5; f_resp_ready = 1'b1;
        #1;
        check("t1_f_req_ready", f_req_ready, 1);
        check("t1_mem_addr", mem_addr, 5);
        f_q.push_back(32'h0050_0093);
        cycle();
        f_req_valid = 1'b0;
        check("t1_f_resp_valid", f_resp_valid, 1);
        check("t1_f_resp_data", f_resp_data, 32'h0050_0093);
        cycle();
        check("t1_idle", f_resp_valid, 0);

        // Round-robin under continuous dual request
        do_reset();
        f_req_valid = 1'b1; f_req_addr = 6'd1; f_resp_ready = 1'b1;
        d_req_valid = 1'b1; d_req_addr = 6'd2; d_resp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("t2_f_req_ready", f_req_ready, (i % 2 == 0) ? 1 : 0);
            check("t2_d_req_ready", d_req_ready, (i % 2 == 1) ? 1 : 0);
            check("t2_mem_addr", mem_addr, (i % 2 == 0) ? 1 : 2);
            if (i % 2 == 0) f_q.push_back(mem[1]);
            else d_q.push_back(mem[2]);
            cycle();
        end
        f_req_valid = 1'b0; d_req_valid = 1'b0;
        check("t2_f_cnt", f_grant_cnt, sat(3));
        check("t2_d_cnt", d_grant_cnt, sat(3));
        cycle();
        check("t2_drained", d_resp_valid, 0);

        // Backpressure on a held fetch response
        do_reset();
        f_req_valid = 1'b1; f_req_addr = 6'd4;
        #1;
        check("t3_f_req_ready", f_req_ready, 1);
        f_q.push_back(mem[4]);
        cycle();
        f_req_valid = 1'b0;
        d_req_valid = 1'b1; d_req_addr = 6'd6;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t3_d_blocked", d_req_ready, 0);
            check("t3_f_held_data", f_resp_data, mem[4]);
            cycle();
        end
        f_resp_ready = 1'b1;
        #1;
        check("t3_d_granted", d_req_ready, 1);
        d_q.push_back(mem[6]);
        cycle();
        d_req_valid = 1'b0; f_resp_ready = 1'b0;
        check("t3_d_resp_valid", d_resp_valid, 1);
        check("t3_f_resp_valid", f_resp_valid, 0);
        d_resp_ready = 1'b1;
        cycle();
        d_resp_ready = 1'b0;

        // Flush discards held fetch; same-cycle debug grant
        do_reset();
        f_req_valid = 1'b1; f_req_addr = 6'd8;
        #1;
        f_q.push_back(mem[8]);
        cycle();
        flush = 1'b1; f_req_addr = 6'd9;
        d_req_valid = 1'b1; d_req_addr = 6'd7;
        #1;
        check("t4_f_req_ready_flush", f_req_ready, 0);
        check("t4_d_req_ready", d_req_ready, 1);
        check("t4_mem_addr", mem_addr, 7);
        d_q.push_back(mem[7]);
        cycle();
        flush = 1'b0; f_req_valid = 1'b0; d_req_valid = 1'b0;
        check("t4_f_resp_valid", f_resp_valid, 0);
        check("t4_d_resp_valid", d_resp_valid, 1);
        check("t4_d_resp_data", d_resp_data, mem[7]);
        d_resp_ready = 1'b1;
        cycle();
        d_resp_ready = 1'b0;

        // Asynchronous reset while holding
        do_reset();
        f_req_valid = 1'b1; f_req_addr = 6'd10;
        #1;
        f_q.push_back(mem[10]);
        cycle();
        f_req_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        f_q.delete();
        #1;
        check("t5_async_drop", f_resp_valid, 0);
        do_reset();
        f_req_valid = 1'b1; f_req_addr = 6'd3; f_resp_ready = 1'b1;
        #1;
        check("t5_first_grant", f_req_ready, 1);
        f_q.push_back(mem[3]);
        cycle();
        f_req_valid = 1'b0;
        check("t5_f_resp_valid", f_resp_valid, 1);
        check("t5_f_resp_data", f_resp_data, mem[3]);
        cycle();

        // Grant counter saturation
        do_reset();
        check("t6_cnt_reset", f_grant_cnt, 0);
        f_resp_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            f_req_valid = 1'b1; f_req_addr = 6'(k);
            #1;
            check("t6_f_req_ready", f_req_ready, 1);
            f_q.push_back(mem[k]);
            cycle();
            check("t6_f_cnt", f_grant_cnt, sat(k));
            check("t6_d_cnt", d_grant_cnt, 0);
        end
        f_req_valid = 1'b0;
        cycle();

        check("final_f_q_empty", f_q.size(), 0);
        check("final_d_q_empty", d_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
